alu_multicycle: RTL and testbench
=================================

// Module: alu_multicycle
// PURPOSE
//   Execute-stage ALU for the single-issue MIPS core. It consumes the 3-bit
//   op code from ALU_Control (1:+ 2:- 3:& 4:| 5:*), plus the two operands from
//   the ID/EX register, and returns a registered result.
//   ADD/SUB/AND/OR complete in 1 cycle. MUL runs on an iterative shift-add
//   multiplier taking WIDTH cycles, and the block stalls the pipeline meanwhile.
// PARAMETERS
//   WIDTH      32   operand/result width; the MUL iteration count equals WIDTH
// PORTS
//   clk_i      in   1      clock, all state on rising edge
//   rst_i      in   1      synchronous reset, active-high
//   valid_i    in   1      operands and op code valid this cycle
//   ALUCtrl_i  in   3      op code from ALU_Control
//   data1_i    in   WIDTH  operand A (rs)
//   data2_i    in   WIDTH  operand B (rt or sign-extended immediate)
//   ready_o    out  1      block can accept a new op this cycle
//   stall_o    out  1      ~ready_o; freezes IF/ID/EX upstream
//   valid_o    out  1      one-cycle pulse: data_o/zero_o hold a new result
//   data_o     out  WIDTH  registered result, held until the next result
//   zero_o     out  1      registered (data_o == 0), updated with data_o
// BEHAVIOUR
//   Reset, on the edge where rst_i=1:
//   - state=IDLE, ready_o=1, stall_o=0, valid_o=0, data_o=0, zero_o=1.
//   - Reset overrides valid_i on the same edge.
//   Accept: an op is taken on edge E0 when valid_i && ready_o.
//   - valid_i while ready_o=0 is ignored, never queued.
//   FSM IDLE -> IDLE, for op 1..4 or undefined codes 0/6/7:
//   - At E0: data_o <= result, valid_o <= 1. Latency is 1.
//   - Undefined codes give result 0.
//   FSM IDLE -> MUL, for op 5:
//   - At E0: latch A into the multiplicand and B into the multiplier.
//     Clear the accumulator, cnt <= 0, ready_o <= 0.
//   - Edges E1..E32 (WIDTH iterations):
//     if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
//   - At the edge where cnt == WIDTH-1 (E32): write the result to data_o,
//     valid_o <= 1, ready_o <= 1, state <= IDLE.
//   - MUL latency is WIDTH cycles. ready_o is low for exactly WIDTH cycles.
//   Back-to-back: a new op may be accepted in the same cycle valid_o is high.
//   - valid_o clears on the next edge unless a 1-cycle op was accepted there.
//   Arithmetic rules:
//   - Modulo 2^WIDTH. No overflow or carry outputs.
//   - SUB is A + ~B + 1.
//   - MUL returns the low WIDTH bits of the product, which are identical
//     for signed and unsigned operands.
//   Operands are latched at E0, so later changes to data*_i have no effect
//   on an in-flight MUL.
//   Reset mid-MUL: the iteration is abandoned with no valid_o pulse, and all
//   outputs return to their reset values on that edge.
// STRUCTURE
//   alu_pkg: localparams ALU_ADD=3'd1, ALU_SUB=3'd2, ALU_AND=3'd3,
//   ALU_OR=3'd4, ALU_MUL=3'd5, and the state encoding IDLE/MUL.
//   These are shared with ALU_Control.
//   Sub-module seq_multiplier (start/busy/done, WIDTH param) holds the
//   shift-add datapath and counter. The top holds the 1-cycle datapath,
//   the FSM and the output registers.
// TESTING
//   1 rst_i high 2 cycles -> valid_o=0, data_o=0, zero_o=1, ready_o=1.
//   2 ADD 5+7 -> next cycle valid_o=1, data_o=12, zero_o=0.
//     SUB 3-5 -> data_o=0xFFFFFFFE.
//     SUB 9-9 -> zero_o=1.
//   3 AND 0xF0F0F0F0,0xFF00FF00 -> 0xF000F000.
//     OR of the same operands issued back-to-back -> 0xFFF0FFF0.
//     valid_o stays high for 2 consecutive cycles.
//   4 MUL 3 x 0xFFFFFFFF -> ready_o/stall_o high-then-low for 32 cycles.
//     valid_o pulses once, 32 cycles after acceptance, with
//     data_o=0xFFFFFFFD.
//     ADD with valid_i=1 during the stall is ignored.
//   5 MUL 0x10000 x 0x10000 -> data_o=0, zero_o=1.
//     MUL 1234 x 5678 -> 7006652.
//   6 Start MUL 7x6, assert rst_i 10 cycles after acceptance -> next cycle
//     ready_o=1, data_o=0, and no valid_o pulse ever appears.
//     A following ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_multicycle_pkg.sv
// Op codes shared with ALU_Control and the ALU sequencer state encoding.
// Imported by the ALU top and its testbench-facing interface users.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the ID/EX stage and the execute ALU.
// The master issues operands and op code; the slave (ALU) returns results.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);

  logic             valid_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic             ready_o;
  logic             stall_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             zero_o;

  modport master (
    output valid_i, ALUCtrl_i, data1_i, data2_i,
    input  ready_o, stall_o, valid_o, data_o, zero_o
  );

  modport slave (
    input  valid_i, ALUCtrl_i, data1_i, data2_i,
    output ready_o, stall_o, valid_o, data_o, zero_o
  );

endinterface

// File: rtl/alu_multicycle_seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// o_done is high during the final iteration; o_product is the sum it produces.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplier,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] w_acc_next;

  // Only the low WIDTH bits are kept, which is the full answer modulo 2^WIDTH.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == LAST) r_busy <= 1'b0;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/OR, WIDTH-cycle MUL that stalls
// the pipeline. Results are registered and announced with a one-cycle valid_o.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  alu_multicycle_if.slave bus
);

  alu_state_e       r_state;
  alu_state_e       w_state_next;
  logic             w_accept;
  logic             w_start_mul;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_product;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_valid;

  assign w_accept = bus.valid_i && (r_state == IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_alu_result = '0;
    case (bus.ALUCtrl_i)
      ALU_ADD: w_alu_result = bus.data1_i + bus.data2_i;
      ALU_SUB: w_alu_result = bus.data1_i + ~bus.data2_i + WIDTH'(1);
      ALU_AND: w_alu_result = bus.data1_i & bus.data2_i;
      ALU_OR:  w_alu_result = bus.data1_i | bus.data2_i;
      default: w_alu_result = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_start_mul  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (bus.ALUCtrl_i == ALU_MUL)) begin
          w_state_next = MUL;
          w_start_mul  = 1'b1;
        end
      end
      // An idle multiplier while in MUL can only mean lost sync; recover to IDLE.
      MUL: if (w_mul_done || !w_mul_busy) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_start   (w_start_mul),
    .i_mcand   (bus.data1_i),
    .i_mplier  (bus.data2_i),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_product)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_valid <= 1'b0;
      if (r_state == MUL && w_mul_done) begin
        r_data  <= w_mul_product;
        r_zero  <= (w_mul_product == '0);
        r_valid <= 1'b1;
      end else if (w_accept && (bus.ALUCtrl_i != ALU_MUL)) begin
        r_data  <= w_alu_result;
        r_zero  <= (w_alu_result == '0);
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.ready_o = (r_state == IDLE);
  assign bus.stall_o = (r_state != IDLE);
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_data;
  assign bus.zero_o  = r_zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: the driver queues expected results from
// a plain-arithmetic model; a negedge monitor pops them on every valid_o.
module tb_alu_multicycle;

  localparam int W = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ready_low = 0;
  int last_valid_cyc = -1;
  int prev_valid_cyc = -1;
  logic [W-1:0] exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: results straight from the arithmetic definitions.
  function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] p;
    case (op)
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[W-1:0];
      end
      default: return '0;
    endcase
  endfunction

  always @(negedge clk_i) begin
    logic [W-1:0] e;
    check("stall_o vs ready_o", W'(bus.stall_o), W'(!bus.ready_o));
    if (!bus.ready_o) n_ready_low++;
    if (bus.valid_o) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      n_valid++;
      if (exp_q.size() == 0) begin
        check("spurious valid_o", W'(bus.valid_o), '0);
      end else begin
        e = exp_q.pop_front();
        check("data_o", bus.data_o, e);
        check("zero_o", W'(bus.zero_o), W'(e == '0));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op; returns the cycle number of the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int acc_cyc);
    int t = 0;
    while (!bus.ready_o && t < 100) begin
      tick();
      t++;
    end
    check("ready_o before issue", W'(bus.ready_o), W'(1));
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    exp_q.push_back(ref_model(op, a, b));
    tick();
    acc_cyc     = cyc;
    bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    tick();
    check("scoreboard drained", W'(exp_q.size()), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, nv0, lo0;
    logic [2:0] op;
    logic [W-1:0] a, b;

    bus.valid_i   = 1'b0;
    bus.ALUCtrl_i = '0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;

    // 1: reset values
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    check("reset valid_o", W'(bus.valid_o), '0);
    check("reset data_o", bus.data_o, '0);
    check("reset zero_o", W'(bus.zero_o), W'(1));
    check("reset ready_o", W'(bus.ready_o), W'(1));
    tick();

    // 2: single-cycle latency and SUB/zero cases
    send(3'd1, 32'd5, 32'd7, acc);
    tick();
    check("ADD latency", W'(last_valid_cyc - acc), '0);
    send(3'd2, 32'd3, 32'd5, acc);
    send(3'd2, 32'd9, 32'd9, acc);
    send(3'd0, 32'd9, 32'd9, acc);
    send(3'd7, 32'd1, 32'd2, acc);
    drain();

    // 3: back-to-back AND then OR
    send(3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, acc);
    send(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, acc2);
    drain();
    check("back-to-back accept spacing", W'(acc2 - acc), W'(1));
    check("valid_o two consecutive cycles", W'(last_valid_cyc - prev_valid_cyc), W'(1));

    // 4: MUL stall length, ignored ADD, operand latching
    lo0 = n_ready_low;
    nv0 = n_valid;
    send(3'd5, 32'd3, 32'hFFFF_FFFF, acc);
    check("ready_o low after MUL accept", W'(bus.ready_o), '0);
    repeat (3) tick();
    bus.valid_i   = 1'b1;
    bus.ALUCtrl_i = 3'd1;
    bus.data1_i   = 32'd100;
    bus.data2_i   = 32'd200;
    repeat (5) tick();
    bus.valid_i = 1'b0;
    drain();
    repeat (3) tick();
    check("MUL valid_o pulse count", W'(n_valid - nv0), W'(1));
    check("MUL latency", W'(last_valid_cyc - acc), W'(W));
    check("MUL ready_o low cycles", W'(n_ready_low - lo0), W'(W));

    // 5: more MUL corners
    send(3'd5, 32'h0001_0000, 32'h0001_0000, acc);
    send(3'd5, 32'd1234, 32'd5678, acc);
    send(3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
    drain();

    // 6: reset mid-MUL
    send(3'd5, 32'd7, 32'd6, acc);
    repeat (9) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_q.delete();
    nv0 = n_valid;
    check("mid-MUL reset ready_o", W'(bus.ready_o), W'(1));
    check("mid-MUL reset data_o", bus.data_o, '0);
    check("mid-MUL reset zero_o", W'(bus.zero_o), W'(1));
    check("mid-MUL reset valid_o", W'(bus.valid_o), '0);
    repeat (40) tick();
    check("no valid_o after reset", W'(n_valid - nv0), '0);
    send(3'd1, 32'd1, 32'd1, acc);
    drain();

    // Random mix, issued back-to-back whenever ready_o allows
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      if ($urandom_range(0, 5) == 0) b = a;
      send(op, a, b, acc);
      if ($urandom_range(0, 2) == 0) tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
